muldiv_seq: RTL
===============

Name: muldiv_seq

Overview:
- Multi-cycle signed multiply/divide unit; replaces the single-cycle combinational MULT (CTRL=0001) and DIV (CTRL=0010) paths in EX.
- Sequences one shift-add or restoring-subtract step per clock.
- Start/busy/done handshake toward EX control; result outputs use the same convention as the ALU (ALU_Result, Remainder, Overflow_flag).

Parameters:
WIDTH, 16, operand width in bits; product is 2*WIDTH, split into ALU_Result (low half) and Remainder (high half).

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request; sampled only in IDLE
CTRL  input  4  0001 = multiply, 0010 = divide; any other value is ignored
MUX_intop  input  WIDTH  signed operand A (multiplicand / dividend)
MUX_inbottom  input  WIDTH  signed operand B (multiplier / divisor)
busy  output  1  high from the edge that accepts start until the edge that enters DONE
done  output  1  one-cycle pulse; results valid
ALU_Result  output  WIDTH  product low half / quotient
Remainder  output  WIDTH  product high half / remainder
Overflow_flag  output  1  divide error (divide by zero or most-negative / -1)

Behaviour:
- Reset: all outputs, registers, counter and state go to 0 / IDLE immediately. Reset mid-operation discards that operation; no done pulse.
- States: IDLE, CALC, FIX, DONE.

IDLE:
- On start=1 with valid CTRL, latch the operands, the magnitudes |A| and |B| as WIDTH-bit unsigned, the sign bits and the op.
- Set busy=1, count=WIDTH-1, go to CALC.
- start=1 with invalid CTRL: no effect, stay in IDLE.
- Divide with B=0, or A=most-negative with B=-1: skip CALC and FIX, go directly to DONE with ALU_Result=0, Remainder=0, Overflow_flag=1.

CALC:
- One step per clock for WIDTH clocks; leave to FIX when count==0.
- Multiply: unsigned shift-add on magnitudes into a 2*WIDTH accumulator.
- Divide: restoring division on magnitudes.

FIX, one clock:
- Multiply: negate the 2*WIDTH product if the operand signs differ.
- Divide: negate the quotient if the signs differ. Negate the remainder if the dividend is negative (truncate toward zero; remainder takes the dividend's sign).
- Write ALU_Result, Remainder and Overflow_flag=0, then go to DONE.

DONE, one clock:
- done=1 and busy=0; return to IDLE.
- start is not accepted in DONE.

Latency and output timing:
- Normal ops: done is high in the cycle after edge WIDTH+2, counting the accepting edge as edge 0 (18 clocks for WIDTH=16).
- Error ops: done is high in the cycle after edge 1.
- Outputs hold their values after done until the next FIX or error completion.
- start while busy or in DONE is ignored; operands are not resampled.

Arithmetic and width rules:
- Magnitude of the most-negative value = 2^(WIDTH-1), which fits unsigned WIDTH bits.
- Product of -2^(WIDTH-1) squared = 2^(2*WIDTH-2); this is correct, no overflow.
- Multiply never sets Overflow_flag.

Optional Feature:
- Macro: MULDIV_ABORT_EN.
- With the macro: an extra input abort (1 bit).
- abort=1 in CALC or FIX returns to IDLE on the next edge. busy drops, no done pulse, and the outputs keep their previous values.
- abort in IDLE or DONE has no effect.
- abort and start together in IDLE: start wins.
- Without the macro: no abort port. Every accepted operation runs to DONE unless rst is asserted.

Test Plan:
- MULT 300 * -7 -> after 18 clocks done=1, ALU_Result=0xF7CC, Remainder=0xFFFF, Overflow_flag=0; busy high for exactly the 17 clocks before done.
- MULT -32768 * -32768 -> ALU_Result=0x0000, Remainder=0x4000, Overflow_flag=0.
- DIV -100 / 7 -> ALU_Result=0xFFF2 (-14), Remainder=0xFFFE (-2); DIV 100 / -7 -> 0xFFF2, 0x0002.
- DIV 5 / 0 and DIV -32768 / -1 -> done one clock after accept, ALU_Result=0, Remainder=0, Overflow_flag=1.
- Accept MULT 3*4, re-pulse start with 9*9 at clock 5 -> result 12 only, one done pulse.
- Assert rst at clock 8 of a DIV -> busy=0, outputs 0, no done; a new op afterwards completes normally.
- (MULDIV_ABORT_EN) abort at clock 6 of MULT -> no done, previous ALU_Result kept; next MULT 2*2 -> 4.

Source files
------------

// File: rtl/muldiv_seq.sv
// ---------------------------------------------------------------------------
// muldiv_seq : multi-cycle signed multiply / divide unit for the EX stage.
//
// The unit performs one shift-add (multiply) or one restoring-subtract
// (divide) step per clock on operand magnitudes. A single FIX cycle then
// applies the result signs. Control is a start/busy/done handshake.
//
// Optional build macro: MULDIV_ABORT_EN adds the 'abort' input. When abort
// is high in CALC or FIX, the unit returns to IDLE on the next edge. No done
// pulse is produced and the outputs keep their previous values.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   start          request, sampled only in IDLE
//   CTRL[3:0]      4'b0001 = multiply, 4'b0010 = divide, others ignored
//   MUX_intop      signed operand A (multiplicand / dividend)
//   MUX_inbottom   signed operand B (multiplier / divisor)
//   abort          (MULDIV_ABORT_EN only) cancel the running operation
//   busy           high from the accepting edge until the edge entering DONE
//   done           one-cycle pulse, results valid
//   ALU_Result     product low half / quotient
//   Remainder      product high half / remainder
//   Overflow_flag  divide error (divide by zero or most-negative / -1)
// ---------------------------------------------------------------------------
module muldiv_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       CTRL,
  input  logic [WIDTH-1:0] MUX_intop,
  input  logic [WIDTH-1:0] MUX_inbottom,
`ifdef MULDIV_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_Result,
  output logic [WIDTH-1:0] Remainder,
  output logic             Overflow_flag
);

  localparam logic [3:0]       CTRL_MUL = 4'b0001;
  localparam logic [3:0]       CTRL_DIV = 4'b0010;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MINUS_ONE = {WIDTH{1'b1}};
  localparam int               CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_reg;
  logic [CW-1:0]      count_reg;
  logic [2*WIDTH-1:0] acc_reg;     // mul: {partial product, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   mag_a_reg;
  logic [WIDTH-1:0]   mag_b_reg;
  logic               sign_a_reg;
  logic               sign_b_reg;
  logic               op_div_reg;

  logic               abort_req;
`ifdef MULDIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Magnitudes of the incoming operands. The most-negative value maps to
  // 2^(WIDTH-1), which is still representable as an unsigned WIDTH-bit value.
  logic [WIDTH-1:0] in_mag_a;
  logic [WIDTH-1:0] in_mag_b;
  logic             op_valid;
  logic             div_err;

  assign in_mag_a = MUX_intop[WIDTH-1]    ? (~MUX_intop + 1'b1)    : MUX_intop;
  assign in_mag_b = MUX_inbottom[WIDTH-1] ? (~MUX_inbottom + 1'b1) : MUX_inbottom;
  assign op_valid = (CTRL == CTRL_MUL) || (CTRL == CTRL_DIV);
  assign div_err  = (CTRL == CTRL_DIV) &&
                    ((MUX_inbottom == '0) ||
                     ((MUX_intop == MOST_NEG) && (MUX_inbottom == MINUS_ONE)));

  // One iteration of each algorithm, computed from the current accumulator.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_acc_next;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_acc_next;

  always_comb begin
    mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} +
                   (acc_reg[0] ? {1'b0, mag_a_reg} : {(WIDTH+1){1'b0}});
    // Shift right with the adder carry entering the top bit.
    mul_acc_next = {mul_sum, acc_reg[WIDTH-1:1]};

    // Shift the next dividend bit into the partial remainder and try a subtract.
    div_shift    = acc_reg[2*WIDTH-1:WIDTH-1];
    div_diff     = div_shift - {1'b0, mag_b_reg};
    div_ge       = (div_shift >= {1'b0, mag_b_reg});
    div_acc_next = div_ge ? {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1}
                          : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};
  end

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  always_comb begin
    prod_fixed = (sign_a_reg ^ sign_b_reg) ? (~acc_reg + 1'b1) : acc_reg;
    quo_fixed  = (sign_a_reg ^ sign_b_reg) ? (~acc_reg[WIDTH-1:0] + 1'b1)
                                           : acc_reg[WIDTH-1:0];
    // Remainder follows the dividend's sign (truncating division).
    rem_fixed  = sign_a_reg ? (~acc_reg[2*WIDTH-1:WIDTH] + 1'b1)
                            : acc_reg[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      acc_reg       <= '0;
      mag_a_reg     <= '0;
      mag_b_reg     <= '0;
      sign_a_reg    <= 1'b0;
      sign_b_reg    <= 1'b0;
      op_div_reg    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      ALU_Result    <= '0;
      Remainder     <= '0;
      Overflow_flag <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start && op_valid) begin
            mag_a_reg  <= in_mag_a;
            mag_b_reg  <= in_mag_b;
            sign_a_reg <= MUX_intop[WIDTH-1];
            sign_b_reg <= MUX_inbottom[WIDTH-1];
            op_div_reg <= (CTRL == CTRL_DIV);
            if (div_err) begin
              // Error completions bypass the datapath entirely.
              ALU_Result    <= '0;
              Remainder     <= '0;
              Overflow_flag <= 1'b1;
              state_reg     <= DONE;
            end else begin
              acc_reg   <= (CTRL == CTRL_DIV) ? {{WIDTH{1'b0}}, in_mag_a}
                                              : {{WIDTH{1'b0}}, in_mag_b};
              count_reg <= CW'(WIDTH - 1);
              busy      <= 1'b1;
              state_reg <= CALC;
            end
          end
        end

        CALC: begin
          if (abort_req) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end else begin
            acc_reg <= op_div_reg ? div_acc_next : mul_acc_next;
            if (count_reg == '0) begin
              state_reg <= FIX;
            end else begin
              count_reg <= count_reg - 1'b1;
            end
          end
        end

        FIX: begin
          busy <= 1'b0;
          if (abort_req) begin
            state_reg <= IDLE;
          end else begin
            if (op_div_reg) begin
              ALU_Result <= quo_fixed;
              Remainder  <= rem_fixed;
            end else begin
              ALU_Result <= prod_fixed[WIDTH-1:0];
              Remainder  <= prod_fixed[2*WIDTH-1:WIDTH];
            end
            Overflow_flag <= 1'b0;
            state_reg     <= DONE;
          end
        end

        DONE: begin
          // done is registered, so the pulse is seen in the cycle after DONE.
          done      <= 1'b1;
          state_reg <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
